// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants and select encodings for the MIPS fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

   typedef enum logic [2:0] {
      PC_SEQ  = 3'd0,
      PC_JMP  = 3'd1,
      PC_BR   = 3'd2,
      PC_IRQ  = 3'd3,
      PC_EXC  = 3'd4,
      PC_HOLD = 3'd5
   } pc_sel_e;

   typedef enum logic [1:0] {
      IFID_LOAD   = 2'd0,
      IFID_HOLD   = 2'd1,
      IFID_BUBBLE = 2'd2,
      IFID_IRQ    = 2'd3
   } ifid_op_e;

   // The supervisor bit is preserved; only the low 31 bits count and wrap.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with hold, bubble and IRQ-bubble loads.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  ifid_op_e    op,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] pc_plus4_in,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        valid,
   output logic        irq
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr    <= NOP_INSTR;
         pc       <= 32'h0;
         pc_plus4 <= 32'h0;
         valid    <= 1'b0;
         irq      <= 1'b0;
      end else begin
         case (op)
            IFID_LOAD: begin
               instr    <= instr_in;
               pc       <= pc_in;
               pc_plus4 <= pc_plus4_in;
               valid    <= 1'b1;
               irq      <= 1'b0;
            end
            // An IRQ bubble carries the interrupted PC so ID can save it to $k0.
            IFID_IRQ: begin
               instr    <= NOP_INSTR;
               pc       <= pc_in;
               pc_plus4 <= pc_plus4_in;
               valid    <= 1'b0;
               irq      <= 1'b1;
            end
            IFID_BUBBLE: begin
               instr    <= NOP_INSTR;
               pc       <= pc_in;
               pc_plus4 <= pc_plus4_in;
               valid    <= 1'b0;
               irq      <= 1'b0;
            end
            default: begin
               instr    <= instr;
               pc       <= pc;
               pc_plus4 <= pc_plus4;
               valid    <= valid;
               irq      <= irq;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Brief   : MIPS instruction fetch: PC register, next-PC arbitration, IF/ID.
//           IF_IRQ_KMASK_EN selects level-sensitive, kernel-masked interrupts.
// Revision: 1.0 - initial release
// ============================================================================
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
   parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        exception,
   input  logic        irq,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        if_id_irq
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        irq_accept;
   pc_sel_e     pc_sel;
   ifid_op_e    ifid_op;

   assign pc_plus4  = pc_inc(pc);
   assign imem_addr = pc;

`ifdef IF_IRQ_KMASK_EN
   assign irq_accept = irq & ~pc[31] & ~exception;
`else
   logic irq_prev;
   logic irq_pend;

   // A new edge arriving in the accept cycle re-arms the pending flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_prev <= 1'b0;
         irq_pend <= 1'b0;
      end else begin
         irq_prev <= irq;
         if (irq & ~irq_prev)
            irq_pend <= 1'b1;
         else if (irq_accept)
            irq_pend <= 1'b0;
      end
   end

   assign irq_accept = irq_pend & ~exception;
`endif

   // Jump is an ID-stage request, so a stall holds it in ID until it can issue.
   always_comb begin
      pc_sel = PC_SEQ;
      if (exception)
         pc_sel = PC_EXC;
      else if (irq_accept)
         pc_sel = PC_IRQ;
      else if (branch_taken)
         pc_sel = PC_BR;
      else if (stall)
         pc_sel = PC_HOLD;
      else if (jump)
         pc_sel = PC_JMP;
   end

   always_comb begin
      pc_next = pc_plus4;
      case (pc_sel)
         PC_EXC:  pc_next = EXC_VEC;
         PC_IRQ:  pc_next = IRQ_VEC;
         PC_BR:   pc_next = branch_target;
         PC_JMP:  pc_next = jump_target;
         PC_HOLD: pc_next = pc;
         default: pc_next = pc_plus4;
      endcase
   end

   always_comb begin
      ifid_op = IFID_LOAD;
      if (exception | branch_taken | flush)
         ifid_op = IFID_BUBBLE;
      else if (irq_accept)
         ifid_op = IFID_IRQ;
      else if (stall)
         ifid_op = IFID_HOLD;
      else if (jump)
         ifid_op = IFID_BUBBLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pc <= RESET_VEC;
      else
         pc <= pc_next;
   end

   if_id_reg u_if_id_reg (
      .clk         (clk),
      .reset       (reset),
      .op          (ifid_op),
      .instr_in    (imem_rdata),
      .pc_in       (pc),
      .pc_plus4_in (pc_plus4),
      .instr       (if_id_instr),
      .pc          (if_id_pc),
      .pc_plus4    (if_id_pc_plus4),
      .valid       (if_id_valid),
      .irq         (if_id_irq)
   );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Brief   : Directed and randomized checks of if_stage against a fetch model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] RV = 32'h8000_0000;
   localparam logic [31:0] IV = 32'h8000_0004;
   localparam logic [31:0] EV = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset, stall, flush, jump, branch_taken, exception, irq;
   logic [31:0] jump_target, branch_target;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
   logic        if_id_valid, if_id_irq;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[9:2]];

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .jump           (jump),
      .jump_target    (jump_target),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .exception      (exception),
      .irq            (irq),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .if_id_irq      (if_id_irq)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
   logic        m_valid, m_irq, m_prev, m_pend;

   function automatic logic [31:0] plus4(input logic [31:0] a);
      logic [31:0] s;
      s = a + 32'd4;
      return {a[31], s[30:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_addr"},  imem_addr, m_pc);
      check({tag, "_instr"}, if_id_instr, m_instr);
      check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
      check({tag, "_irq"},   {31'd0, if_id_irq}, {31'd0, m_irq});
      if (m_valid || m_irq) begin
         check({tag, "_ipc"}, if_id_pc, m_ipc);
         check({tag, "_ip4"}, if_id_pc_plus4, m_ip4);
      end
   endtask

   task automatic model_reset();
      m_pc = RV; m_instr = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
      m_valid = 1'b0; m_irq = 1'b0; m_prev = 1'b0; m_pend = 1'b0;
   endtask

   // Asserts reset asynchronously, between clock edges.
   task automatic do_reset();
      reset = 1'b0;
      #2;
      model_reset();
      check_all("rst");
      check("rst_ipc", if_id_pc, 32'h0);
      check("rst_ip4", if_id_pc_plus4, 32'h0);
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   task automatic step(input logic st, input logic fl, input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic ex, input logic iq);
      logic        acc, nv, nirq, npend;
      logic [31:0] npc, ni, nipc, nip4;
      stall = st; flush = fl; jump = jp; jump_target = jt;
      branch_taken = br; branch_target = bt; exception = ex; irq = iq;
`ifdef IF_IRQ_KMASK_EN
      acc = iq && !m_pc[31] && !ex;
`else
      acc = m_pend && !ex;
`endif
      if (ex)       npc = EV;
      else if (acc) npc = IV;
      else if (br)  npc = bt;
      else if (st)  npc = m_pc;
      else if (jp)  npc = jt;
      else          npc = plus4(m_pc);

      ni = m_instr; nipc = m_ipc; nip4 = m_ip4; nv = m_valid; nirq = m_irq;
      if (ex || br || fl) begin
         ni = 32'h0; nv = 1'b0; nirq = 1'b0;
      end else if (acc) begin
         ni = 32'h0; nv = 1'b0; nirq = 1'b1; nipc = m_pc; nip4 = plus4(m_pc);
      end else if (st) begin
         nv = m_valid;
      end else if (jp) begin
         ni = 32'h0; nv = 1'b0; nirq = 1'b0;
      end else begin
         ni = mem[m_pc[9:2]]; nipc = m_pc; nip4 = plus4(m_pc); nv = 1'b1; nirq = 1'b0;
      end
      npend = (iq && !m_prev) ? 1'b1 : (acc ? 1'b0 : m_pend);

      @(posedge clk);
      #1;
      m_pc = npc; m_instr = ni; m_ipc = nipc; m_ip4 = nip4;
      m_valid = nv; m_irq = nirq; m_pend = npend; m_prev = iq;
      check_all("step");
   endtask

   task automatic idle(input logic iq);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, iq);
   endtask

   task automatic go(input logic [31:0] t);
      step(1'b0, 1'b0, 1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      stall = 0; flush = 0; jump = 0; jump_target = 0;
      branch_taken = 0; branch_target = 0; exception = 0; irq = 0;
      reset = 1'b1;
      #7;
      do_reset();

      // Reset vector, then first sequential fetch
      check("t1_addr", imem_addr, 32'h8000_0000);
      check("t1_valid", {31'd0, if_id_valid}, 32'd0);
      idle(1'b0);
      check("t1_pc2", imem_addr, 32'h8000_0004);
      check("t1_valid2", {31'd0, if_id_valid}, 32'd1);
      check("t1_ipc", if_id_pc, 32'h8000_0000);

      // Stall freezes PC and IF/ID
      go(32'h0000_0010);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t2_hold", imem_addr, 32'h0000_0010);
      idle(1'b0);
      check("t2_resume", imem_addr, 32'h0000_0014);
      check("t2_ipc", if_id_pc, 32'h0000_0010);
      check("t2_instr", if_id_instr, mem[4]);

      // Jump bubble
      go(32'h0000_0038);
      check("t3_addr", imem_addr, 32'h0000_0038);
      check("t3_instr", if_id_instr, 32'h0);
      idle(1'b0);

      // Branch beats jump and stall
      step(1'b1, 1'b0, 1'b1, 32'h0000_0050, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
      check("t4_addr", imem_addr, 32'h0000_000C);
      check("t4_valid", {31'd0, if_id_valid}, 32'd0);

      // Interrupt from user mode, then irq held high in kernel
      go(32'h0000_0100);
`ifdef IF_IRQ_KMASK_EN
      idle(1'b1);
      check("t5_addr", imem_addr, IV);
      check("t5_irq", {31'd0, if_id_irq}, 32'd1);
      check("t5_ipc", if_id_pc, 32'h0000_0100);
`else
      idle(1'b1);
      check("t5_seq", imem_addr, 32'h0000_0104);
      idle(1'b1);
      check("t5_addr", imem_addr, IV);
      check("t5_irq", {31'd0, if_id_irq}, 32'd1);
      check("t5_ipc", if_id_pc, 32'h0000_0104);
`endif
      repeat (3) idle(1'b1);
      check("t5_noreent", imem_addr, 32'h8000_0010);
      idle(1'b0);

      // Exception and irq together
      go(32'h0000_0200);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("t6_exc", imem_addr, EV);
      idle(1'b1);
`ifdef IF_IRQ_KMASK_EN
      check("t6_masked", imem_addr, 32'h8000_000C);
`else
      check("t6_irq_next", imem_addr, IV);
      check("t6_ipc", if_id_pc, EV);
`endif
      idle(1'b0);

      // Low 31 bits wrap, supervisor bit preserved
      go(32'h7FFF_FFFC);
      idle(1'b0);
      check("wrap_user", imem_addr, 32'h0000_0000);
      go(32'hFFFF_FFFC);
      idle(1'b0);
      check("wrap_kern", imem_addr, 32'h8000_0000);
      check("wrap_ip4", if_id_pc_plus4, 32'h8000_0000);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic st, fl, jp, br, ex, iq;
         st = ($urandom_range(0, 99) < 20);
         fl = ($urandom_range(0, 99) < 10);
         jp = ($urandom_range(0, 99) < 12);
         br = ($urandom_range(0, 99) < 8);
         ex = ($urandom_range(0, 99) < 3);
         iq = ($urandom_range(0, 99) < 8) ? ~irq : irq;
         step(st, fl, jp, $urandom, br, $urandom, ex, iq);
      end

      // Reset in the middle of a redirect
      stall = 0; flush = 0; jump = 1; jump_target = 32'h0000_0040; irq = 0; exception = 0; branch_taken = 0;
      do_reset();
      idle(1'b0);
      check("rst2_pc", imem_addr, 32'h8000_0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
